systolic_feed_ctrl: RTL and testbench

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl.sv | 128 ++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl.sv
// Feed controller for an N x N output-stationary systolic array: holds the A/B
// operand files, streams skewed rows/columns, then captures the accumulators.
module systolic_feed_ctrl #(
  parameter int N         = 4,
  parameter int DW        = 16,
  parameter int RW        = 32,
  parameter int DRAIN_CYC = 4,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [IW-1:0]       wr_row,
  input  logic [IW-1:0]       wr_col,
  input  logic [DW-1:0]       wr_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                arr_rst_n,
  output logic [N*DW-1:0]     arr_a,
  output logic [N*DW-1:0]     arr_b,
  input  logic [N*N*RW-1:0]   arr_result,
  output logic [N*N*RW-1:0]   res_data
);

  localparam int FEED_LAST = 2*N - 2;
  localparam int CNT_MAX   = (2*N - 1 > DRAIN_CYC) ? 2*N - 1 : DRAIN_CYC;
  localparam int CW        = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   mem_a [N][N];
  logic [DW-1:0]   mem_b [N][N];
  logic [N*DW-1:0] a_next;
  logic [N*DW-1:0] b_next;
  int              feed_step;

  assign busy = (state != IDLE);

  // Lanes are registered, so the value for the coming step is prepared one
  // cycle ahead: step 0 during CLEAR, step cnt+1 during FEED step cnt.
  always_comb begin
    a_next    = '0;
    b_next    = '0;
    feed_step = (state == CLEAR) ? 0 : int'(cnt) + 1;
    if (state == CLEAR || (state == FEED && int'(cnt) != FEED_LAST)) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (int'(i + k) == feed_step) begin
            a_next[DW*i +: DW] = mem_a[i][k];
            b_next[DW*i +: DW] = mem_b[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      arr_a     <= '0;
      arr_b     <= '0;
      arr_rst_n <= 1'b0;
      done      <= 1'b0;
      res_data  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned k = 0; k < N; k++) begin
          mem_a[i][k] <= '0;
          mem_b[i][k] <= '0;
        end
      end
    end else begin
      arr_a     <= a_next;
      arr_b     <= b_next;
      arr_rst_n <= 1'b1;
      done      <= 1'b0;

      if (wr_en && state == IDLE) begin
        if (wr_sel) mem_b[wr_row][wr_col] <= wr_data;
        else        mem_a[wr_row][wr_col] <= wr_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            arr_rst_n <= 1'b0;
          end
        end
        CLEAR: begin
          state <= FEED;
          cnt   <= '0;
        end
        FEED: begin
          if (int'(cnt) == FEED_LAST) begin
            cnt <= '0;
            if (DRAIN_CYC == 0) begin
              state    <= DONE;
              res_data <= arr_result;
              done     <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (int'(cnt) == DRAIN_CYC - 1) begin
            state    <= DONE;
            cnt      <= '0;
            res_data <= arr_result;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: a behavioural systolic array stub supplies
// arr_result; expectations come from plain matrix arithmetic on a shadow copy.
module tb_systolic_feed_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 32;
  localparam int D  = 4;
  localparam int IW = 2;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic              wr_sel;
  logic [IW-1:0]     wr_row;
  logic [IW-1:0]     wr_col;
  logic [DW-1:0]     wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              arr_rst_n;
  logic [N*DW-1:0]   arr_a;
  logic [N*DW-1:0]   arr_b;
  logic [N*N*RW-1:0] arr_result;
  logic [N*N*RW-1:0] res_data;

  systolic_feed_ctrl #(.N(N), .DW(DW), .RW(RW), .DRAIN_CYC(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy),
    .done(done), .arr_rst_n(arr_rst_n), .arr_a(arr_a), .arr_b(arr_b),
    .arr_result(arr_result), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output-stationary array stand-in: A flows right, B flows down.
  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];
  logic [DW-1:0] ain [N][N];
  logic [DW-1:0] bin [N][N];
  logic [RW-1:0] acc [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ain[i][j] = '0;
        bin[i][j] = '0;
        if (j == 0) ain[i][j] = arr_a[DW*i +: DW];
        else        ain[i][j] = pa[i][j-1];
        if (i == 0) bin[i][j] = arr_b[DW*j +: DW];
        else        bin[i][j] = pb[i-1][j];
        arr_result[(N*i+j)*RW +: RW] = acc[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pa[i][j] <= ain[i][j];
        pb[i][j] <= bin[i][j];
        if (arr_rst_n !== 1'b1) acc[i][j] <= '0;
        else acc[i][j] <= acc[i][j] + RW'(ain[i][j]) * RW'(bin[i][j]);
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int ma [N][N];
  int mb [N][N];
  logic [N*N*RW-1:0] prev_res;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N*N*RW-1:0] obs,
                       input logic [N*N*RW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] lane_a(input int s);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (s - i >= 0 && s - i < N) v[DW*i +: DW] = DW'(ma[i][s-i]);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] lane_b(input int s);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (s - j >= 0 && s - j < N) v[DW*j +: DW] = DW'(mb[s-j][j]);
    return v;
  endfunction

  function automatic logic [N*N*RW-1:0] product();
    logic [N*N*RW-1:0] v;
    logic [RW-1:0] sum;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = '0;
        for (int k = 0; k < N; k++) sum = sum + RW'(ma[i][k]) * RW'(mb[k][j]);
        v[(N*i+j)*RW +: RW] = sum;
      end
    return v;
  endfunction

  task automatic wr(input bit sel, input int r, input int c, input int v);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = IW'(r);
    wr_col  = IW'(c);
    wr_data = DW'(v);
    tick();
    wr_en = 1'b0;
    if (sel) mb[r][c] = v;
    else     ma[r][c] = v;
  endtask

  // kind 0: A=B=4i+j+1; kind 1: A=identity, B=4i+j+1; kind 2: random
  task automatic load(input int kind);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (kind == 0)      wr(1'b0, i, j, 4*i + j + 1);
        else if (kind == 1) wr(1'b0, i, j, (i == j) ? 1 : 0);
        else                wr(1'b0, i, j, int'($urandom_range(0, 1000)));
        if (kind == 2) wr(1'b1, i, j, int'($urandom_range(0, 1000)));
        else           wr(1'b1, i, j, 4*i + j + 1);
      end
  endtask

  // Entered and left in an IDLE cycle; checks every cycle of one run.
  task automatic run_mult(input bit glitch, input bit busy_wr, input bit same_wr);
    int lows;
    int r, c0, v;
    logic [N*N*RW-1:0] exp_res;
    lows = 0;
    if (same_wr) begin
      r  = int'($urandom_range(0, N-1));
      c0 = int'($urandom_range(0, N-1));
      v  = int'($urandom_range(1, 1000));
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = IW'(r); wr_col = IW'(c0); wr_data = DW'(v);
      ma[r][c0] = v;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    exp_res = product();
    for (int c = 0; c <= 2*N + D; c++) begin
      if (arr_rst_n !== 1'b1) lows++;
      if (c == 0) check("arr_rst_n clear", arr_rst_n, 1'b0);
      check($sformatf("busy c%0d", c), busy, 1'b1);
      check($sformatf("done c%0d", c), done, (c == 2*N + D) ? 1'b1 : 1'b0);
      check($sformatf("arr_a c%0d", c), arr_a, (c >= 1 && c <= 2*N-1) ? lane_a(c-1) : '0);
      check($sformatf("arr_b c%0d", c), arr_b, (c >= 1 && c <= 2*N-1) ? lane_b(c-1) : '0);
      if (c == 2*N + D) check("res_data", res_data, exp_res);
      else check($sformatf("res_hold c%0d", c), res_data, prev_res);
      if (busy_wr && c == 3) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 16'd99;
      end else begin
        wr_en = 1'b0;
      end
      start = (glitch && (c == 2*N + 1 || c == 2*N + D)) ? 1'b1 : 1'b0;
      if (c < 2*N + D) tick();
    end
    check("arr_rst_n lows", 32'(lows), 32'd1);
    prev_res = exp_res;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check("idle busy", busy, 1'b0);
    check("idle done", done, 1'b0);
    check("idle arr_rst_n", arr_rst_n, 1'b1);
    check("idle arr_a", arr_a, '0);
    check("idle res_data", res_data, prev_res);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; start = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    prev_res = '0;
    tick(); tick();
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst arr_rst_n", arr_rst_n, 1'b0);
    check("rst arr_a", arr_a, '0);
    check("rst arr_b", arr_b, '0);
    check("rst res_data", res_data, '0);
    rst = 1'b0;
    tick();
    check("post rst arr_rst_n", arr_rst_n, 1'b1);

    load(0);
    run_mult(1'b0, 1'b0, 1'b0);
    check("res00", res_data[RW-1:0], 32'd90);
    check("res03", res_data[4*RW-1 -: RW], 32'd120);
    check("res30", res_data[13*RW-1 -: RW], 32'd426);
    check("res33", res_data[16*RW-1 -: RW], 32'd600);

    load(1);
    run_mult(1'b0, 1'b0, 1'b0);
    run_mult(1'b0, 1'b0, 1'b0);

    run_mult(1'b0, 1'b1, 1'b0);
    run_mult(1'b0, 1'b0, 1'b0);
    run_mult(1'b1, 1'b0, 1'b0);
    tick();
    check("glitch idle busy", busy, 1'b0);

    for (int t = 0; t < 3; t++) begin
      load(2);
      run_mult(1'b0, 1'b0, 1'b1);
    end

    load(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("step3 arr_a", arr_a, {16'd13, 16'd10, 16'd7, 16'd4});
    check("step3 arr_b", arr_b, {16'd4, 16'd7, 16'd10, 16'd13});
    rst = 1'b1;
    tick();
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst arr_rst_n", arr_rst_n, 1'b0);
    check("midrst arr_a", arr_a, '0);
    check("midrst arr_b", arr_b, '0);
    check("midrst res_data", res_data, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    prev_res = '0;
    rst = 1'b0;
    tick();
    run_mult(1'b0, 1'b0, 1'b0);
    load(2);
    run_mult(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
